// File: rtl/lut_sweep_pkg.sv
// Shared constants and FSM encoding for the LUT sweep block.
package lut_sweep_pkg;

  // Legal range for the number of function inputs.
  localparam int N_MIN = 2;
  localparam int N_MAX = 6;

  // Reset truth table for the default 4-input configuration.
  localparam logic [15:0] DEFAULT_TABLE = 16'hF232;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    FIN   = 2'd2
  } state_t;

endpackage : lut_sweep_pkg

// File: rtl/lut_sweep_ctr.sv
// N-bit sweep index counter with clear, enable and terminal-count flag.
module lut_sweep_ctr #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [N-1:0] idx,
  output logic         tc
);

  // Index register: clear wins over enable; the owner stops enabling at tc.
  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      idx <= '0;
    end else if (clr) begin
      idx <= '0;
    end else if (en) begin
      idx <= idx + N'(1);
    end
  end

  assign tc = &idx;

endmodule : lut_sweep_ctr

// File: rtl/lut_sweep.sv
// Programmable N-input truth table with a registered evaluation port and
// an exhaustive sweep engine that counts minterms and finds the lowest one.
module lut_sweep
  import lut_sweep_pkg::*;
#(
  parameter int               N          = 4,
  parameter logic [2**N-1:0]  INIT_TABLE = DEFAULT_TABLE
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N-1:0]      in_vec,
  output logic              f,
  input  logic              tbl_we,
  input  logic [2**N-1:0]   tbl_wdata,
  input  logic              start,
  output logic              busy,
  output logic              sweep_valid,
  output logic [N-1:0]      sweep_idx,
  output logic              sweep_f,
  output logic              done,
  output logic [N:0]        ones_cnt,
  output logic [N-1:0]      first_one,
  output logic              wr_err
);

  localparam int TW = 2**N;
  localparam int CW = N + 1;

  // Refuse to elaborate outside the supported input range.
  if (N < N_MIN || N > N_MAX) begin : g_bad_n
    $fatal(1, "lut_sweep: N must be in 2..6");
  end

  state_t         state;
  logic [TW-1:0]  tbl;
  logic           found;
  logic [N-1:0]   idx;
  logic           tc;
  logic           ctr_clr;
  logic           ctr_en;
  logic           sweep_bit;

  // A sweep always begins at index 0 and holds at the last index on exit.
  assign ctr_clr   = (state == IDLE) && start;
  assign ctr_en    = (state == SWEEP) && !tc;
  assign sweep_bit = tbl[idx];

  lut_sweep_ctr #(.N(N)) u_ctr (
    .clk (clk),
    .rst (rst),
    .clr (ctr_clr),
    .en  (ctr_en),
    .idx (idx),
    .tc  (tc)
  );

  // Sample outputs are forced to zero whenever no sample is presented.
  assign sweep_idx = sweep_valid ? idx : '0;
  assign sweep_f   = sweep_valid & sweep_bit;

  // Evaluation port: one-cycle table lookup, independent of the FSM.
  always_ff @(posedge clk) begin
    if (rst) begin
      f <= 1'b0;
    end else begin
      f <= tbl[in_vec];
    end
  end

  // Sweep FSM with registered status outputs and write gating.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      // NOTE: the table is a plain flop vector, not a RAM, so it can and
      // must be loaded with its power-on contents by reset.
      tbl         <= INIT_TABLE;
      busy        <= 1'b0;
      sweep_valid <= 1'b0;
      done        <= 1'b0;
      ones_cnt    <= '0;
      first_one   <= '0;
      found       <= 1'b0;
      wr_err      <= 1'b0;
    end else begin
      done <= 1'b0;

      // Writes are only legal in IDLE; anything else is dropped and flagged.
      if (tbl_we && state != IDLE) begin
        wr_err <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (tbl_we) begin
            tbl <= tbl_wdata;
          end
          if (start) begin
            state       <= SWEEP;
            busy        <= 1'b1;
            sweep_valid <= 1'b1;
            ones_cnt    <= '0;
            first_one   <= '0;
            found       <= 1'b0;
          end
        end

        SWEEP: begin
          if (sweep_bit) begin
            ones_cnt <= ones_cnt + CW'(1);
            if (!found) begin
              first_one <= idx;
              found     <= 1'b1;
            end
          end
          if (tc) begin
            state       <= FIN;
            sweep_valid <= 1'b0;
            done        <= 1'b1;
          end
        end

        FIN: begin
          state <= IDLE;
          busy  <= 1'b0;
        end

        default: begin
          state       <= IDLE;
          busy        <= 1'b0;
          sweep_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule : lut_sweep
